sd_cmd_sender: RTL and testbench

Sequences the SD-card command line: accepts a command index and 32-bit argument, serialises the 48-bit command frame MSB-first on CMD, and generates CRC7 over the first 40 bits with a serial x^7+x^3+1 engine. Optionally captures and checks the 48-bit short response. Sits between the SCSI/disk-emulation host logic and the SD pad, and paces all bit activity with an external SD-bit strobe.

---
 rtl/sd_cmd_sender.sv | 242 ++++++++++++++++++++++++
 tb/tb_sd_cmd_sender.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_cmd_sender - SD CMD-line frame serialiser with CRC7 generation; the
// 48-bit response capture/check path is built only when SD_CMD_RESP_EN is set.
// Revision 1.0
// ---------------------------------------------------------------------------
module sd_cmd_sender #(
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bit_en,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_expect,
  output logic        busy,
  output logic        done,
  output logic        cmd_out,
  output logic        cmd_oe,
  input  logic        cmd_in,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_status,
  output logic        resp_crc_err,
  output logic        resp_timeout
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TX_DATA = 3'd1;
  localparam logic [2:0] S_TX_CRC  = 3'd2;
  localparam logic [2:0] S_TX_END  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
`ifdef SD_CMD_RESP_EN
  localparam logic [2:0] S_RESP_WAIT = 3'd5;
  localparam logic [2:0] S_RESP_RX   = 3'd6;
  localparam logic [7:0] TMO_LAST    = 8'(RESP_TIMEOUT - 1);
`endif

  logic [2:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [39:0] shift_q, shift_d;
  logic [6:0]  crc_q, crc_d;
  logic        cmd_out_q, cmd_out_d;
  logic        cmd_oe_q, cmd_oe_d;

`ifdef SD_CMD_RESP_EN
  logic        rexp_q, rexp_d;
  logic [7:0]  timer_q, timer_d;
  logic [44:0] cap_q, cap_d;
  logic [5:0]  ridx_q, ridx_d;
  logic [31:0] rstat_q, rstat_d;
  logic        rerr_q, rerr_d;
  logic        rtmo_q, rtmo_d;
`endif

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic inv;
    inv = b ^ c[6];
    return {c[5:3], c[2] ^ inv, c[1:0], inv};
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    crc_d     = crc_q;
    cmd_out_d = cmd_out_q;
    cmd_oe_d  = cmd_oe_q;
`ifdef SD_CMD_RESP_EN
    rexp_d    = rexp_q;
    timer_d   = timer_q;
    cap_d     = cap_q;
    ridx_d    = ridx_q;
    rstat_d   = rstat_q;
    rerr_d    = rerr_q;
    rtmo_d    = rtmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TX_DATA;
          cnt_d   = 6'd0;
          crc_d   = 7'd0;
          shift_d = {2'b01, cmd_index, cmd_arg};
`ifdef SD_CMD_RESP_EN
          rexp_d  = resp_expect;
          timer_d = 8'd0;
          cap_d   = '0;
          ridx_d  = 6'd0;
          rstat_d = 32'd0;
          rerr_d  = 1'b0;
          rtmo_d  = 1'b0;
`endif
        end
      end
      S_TX_DATA: begin
        if (bit_en) begin
          cmd_oe_d  = 1'b1;
          cmd_out_d = shift_q[39];
          crc_d     = crc7_step(crc_q, shift_q[39]);
          shift_d   = {shift_q[38:0], 1'b0};
          if (cnt_q == 6'd39) begin
            cnt_d   = 6'd0;
            state_d = S_TX_CRC;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_TX_CRC: begin
        // CRC goes out MSB first; shifting zeros in leaves it cleared afterwards
        if (bit_en) begin
          cmd_out_d = crc_q[6];
          crc_d     = {crc_q[5:0], 1'b0};
          if (cnt_q == 6'd6) begin
            cnt_d   = 6'd0;
            state_d = S_TX_END;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_TX_END: begin
        if (bit_en) begin
          if (cnt_q == 6'd0) begin
            cmd_out_d = 1'b1;
            cnt_d     = 6'd1;
          end else begin
            cmd_oe_d  = 1'b0;
            cmd_out_d = 1'b1;
            cnt_d     = 6'd0;
            crc_d     = 7'd0;
`ifdef SD_CMD_RESP_EN
            state_d   = rexp_q ? S_RESP_WAIT : S_DONE;
`else
            state_d   = S_DONE;
`endif
          end
        end
      end
`ifdef SD_CMD_RESP_EN
      S_RESP_WAIT: begin
        if (bit_en) begin
          if (!cmd_in) begin
            state_d = S_RESP_RX;
            cnt_d   = 6'd0;
            crc_d   = crc7_step(crc_q, 1'b0);
          end else if (timer_q == TMO_LAST) begin
            rtmo_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      S_RESP_RX: begin
        // cnt 0..45 carry bits 46..1; bit 46 falls off the top of cap, leaving 45..1
        if (bit_en) begin
          if (cnt_q <= 6'd38) begin
            crc_d = crc7_step(crc_q, cmd_in);
          end
          if (cnt_q == 6'd46) begin
            ridx_d  = cap_q[44:39];
            rstat_d = cap_q[38:7];
            rerr_d  = (cap_q[6:0] != crc_q) | ~cmd_in;
            state_d = S_DONE;
          end else begin
            cap_d = {cap_q[43:0], cmd_in};
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      shift_q   <= 40'd0;
      crc_q     <= 7'd0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      crc_q     <= crc_d;
      cmd_out_q <= cmd_out_d;
      cmd_oe_q  <= cmd_oe_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign cmd_out = cmd_out_q;
  assign cmd_oe  = cmd_oe_q;

`ifdef SD_CMD_RESP_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rexp_q  <= 1'b0;
      timer_q <= 8'd0;
      cap_q   <= '0;
      ridx_q  <= 6'd0;
      rstat_q <= 32'd0;
      rerr_q  <= 1'b0;
      rtmo_q  <= 1'b0;
    end else begin
      rexp_q  <= rexp_d;
      timer_q <= timer_d;
      cap_q   <= cap_d;
      ridx_q  <= ridx_d;
      rstat_q <= rstat_d;
      rerr_q  <= rerr_d;
      rtmo_q  <= rtmo_d;
    end
  end

  assign resp_index   = ridx_q;
  assign resp_status  = rstat_q;
  assign resp_crc_err = rerr_q;
  assign resp_timeout = rtmo_q;
`else
  logic unused_resp;
  assign unused_resp  = &{1'b0, cmd_in, resp_expect, RESP_TIMEOUT[0]};

  assign resp_index   = 6'd0;
  assign resp_status  = 32'd0;
  assign resp_crc_err = 1'b0;
  assign resp_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_sender.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_sd_cmd_sender - randomized and directed bench with a frame-level model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_sd_cmd_sender;

  localparam int TMO = 64;
`ifdef SD_CMD_RESP_EN
  localparam bit RESP_EN = 1'b1;
`else
  localparam bit RESP_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_TX = 1, P_WAIT = 2, P_RX = 3, P_DONE = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bit_en = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cmd_index = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        resp_expect = 1'b0;
  logic        busy, done, cmd_out, cmd_oe;
  logic        cmd_in = 1'b1;
  logic [5:0]  resp_index;
  logic [31:0] resp_status;
  logic        resp_crc_err, resp_timeout;

  sd_cmd_sender #(.RESP_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .bit_en(bit_en), .start(start),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_expect(resp_expect),
    .busy(busy), .done(done), .cmd_out(cmd_out), .cmd_oe(cmd_oe),
    .cmd_in(cmd_in), .resp_index(resp_index), .resp_status(resp_status),
    .resp_crc_err(resp_crc_err), .resp_timeout(resp_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // CRC7 as polynomial long division: remainder of M(x)*x^7 mod x^7+x^3+1
  function automatic logic [6:0] crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'b1000_1001;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] i, input logic [31:0] a);
    logic [39:0] m;
    m = {2'b01, i, a};
    return {m, crc7(m), 1'b1};
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  int          m_phase = P_IDLE;
  int          m_k = 0, m_wait = 0, m_n = 0, be_cnt = 0;
  logic [47:0] m_frame = '0, m_rx = '0;
  bit          m_rexp = 1'b0;
  logic        exp_oe = 1'b0, exp_out = 1'b1;
  logic [5:0]  exp_idx = '0;
  logic [31:0] exp_st = '0;
  logic        exp_cerr = 1'b0, exp_tmo = 1'b0;
  bit          be_seen = 1'b0;
  logic [47:0] obs_frame = '0;
  int          obs_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      be_seen = bit_en;
      if (m_phase != P_IDLE && bit_en) be_cnt++;
      if (!reset_n) begin
        m_phase = P_IDLE; exp_oe = 1'b0; exp_out = 1'b1;
        exp_idx = '0; exp_st = '0; exp_cerr = 1'b0; exp_tmo = 1'b0;
      end else begin
        case (m_phase)
          P_IDLE: if (start) begin
            m_phase = P_TX; m_k = 0; be_cnt = 0;
            m_frame = mk_frame(cmd_index, cmd_arg);
            m_rexp  = RESP_EN && resp_expect;
            exp_idx = '0; exp_st = '0; exp_cerr = 1'b0; exp_tmo = 1'b0;
            obs_frame = '0; obs_cnt = 0;
          end
          P_TX: if (bit_en) begin
            m_k++;
            if (m_k <= 48) begin
              exp_oe = 1'b1; exp_out = m_frame[48 - m_k];
            end else begin
              exp_oe = 1'b0; exp_out = 1'b1; m_wait = 0;
              m_phase = m_rexp ? P_WAIT : P_DONE;
            end
          end
          P_WAIT: if (bit_en) begin
            if (!cmd_in) begin
              m_phase = P_RX; m_rx = '0; m_n = 1;
            end else begin
              m_wait++;
              if (m_wait == TMO) begin exp_tmo = 1'b1; m_phase = P_DONE; end
            end
          end
          P_RX: if (bit_en) begin
            m_rx = {m_rx[46:0], cmd_in}; m_n++;
            if (m_n == 48) begin
              exp_idx  = m_rx[45:40];
              exp_st   = m_rx[39:8];
              exp_cerr = (m_rx[7:1] != crc7(m_rx[47:8])) || !m_rx[0];
              m_phase  = P_DONE;
            end
          end
          default: m_phase = P_IDLE;
        endcase
      end
      @(negedge clk);
      if (be_seen && cmd_oe === 1'b1) begin
        obs_frame = {obs_frame[46:0], cmd_out}; obs_cnt++;
      end
      chk("busy", 64'(busy), 64'(m_phase != P_IDLE));
      chk("done", 64'(done), 64'(m_phase == P_DONE));
      chk("cmd_oe", 64'(cmd_oe), 64'(exp_oe));
      chk("cmd_out", 64'(cmd_out), 64'(exp_out));
      chk("resp_index", 64'(resp_index), 64'(exp_idx));
      chk("resp_status", 64'(resp_status), 64'(exp_st));
      chk("resp_crc_err", 64'(resp_crc_err), 64'(exp_cerr));
      chk("resp_timeout", 64'(resp_timeout), 64'(exp_tmo));
    end
  end

  // ---------------- bit strobe and card responder ----------------
  int          be_mode = 0, be_period = 4, be_ctr = 0;
  bit          rsp_armed = 1'b0, rsp_active = 1'b0, prev_oe = 1'b0;
  logic [47:0] rsp_word = '0;
  int          rsp_idle = 0, rsp_pos = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin rsp_armed = 1'b0; rsp_active = 1'b0; end
      if (prev_oe && cmd_oe === 1'b0 && rsp_armed) begin rsp_active = 1'b1; rsp_pos = 0; end
      prev_oe = (cmd_oe === 1'b1);
      #1;
      be_ctr++;
      case (be_mode)
        0: bit_en = (be_ctr % be_period == 0);
        1: bit_en = 1'($urandom_range(0, 1));
        default: bit_en = 1'b1;
      endcase
      if (!rsp_active) cmd_in = 1'b1;
      else if (bit_en) begin
        if (rsp_pos >= rsp_idle && rsp_pos < rsp_idle + 48) cmd_in = rsp_word[47 - (rsp_pos - rsp_idle)];
        else cmd_in = 1'b1;
        rsp_pos++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [5:0] i, input logic [31:0] a, input bit rexp);
    @(negedge clk); #2;
    start = 1'b1; cmd_index = i; cmd_arg = a; resp_expect = rexp;
    @(negedge clk); #2;
    start = 1'b0; cmd_index = 6'($urandom); cmd_arg = $urandom; resp_expect = 1'($urandom);
  endtask

  task automatic arm(input logic [47:0] w, input int idle);
    rsp_word = w; rsp_idle = idle; rsp_armed = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 4000);
    if (done !== 1'b1) begin
      tests++; fails++;
      $display("FAIL %s_done_wait: actual=no done required=done within 4000 clk", nm);
    end
  endtask

  task automatic wait_bits(input int nbits);
    int n;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (obs_cnt < nbits && n < 2000);
    if (obs_cnt < nbits) begin
      tests++; fails++;
      $display("FAIL bit_wait: actual=%0d required=%0d bits", obs_cnt, nbits);
    end
  endtask

  function automatic logic [47:0] mk_resp(input logic [5:0] i, input logic [31:0] a);
    logic [39:0] m;
    m = {2'b00, i, a};
    return {m, crc7(m), 1'b1};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [47:0] rw;
    logic [5:0]  ri;
    logic [31:0] ra;
    int          idle;
    bit          rexp;

    repeat (3) @(negedge clk);
    chk("reset_cmd_oe", 64'(cmd_oe), 64'd0);
    chk("reset_cmd_out", 64'(cmd_out), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    #2 reset_n = 1'b1;

    be_mode = 0; be_period = 4;
    send(6'd0, 32'h0, 1'b0); wait_done("cmd0");
    chk("cmd0_frame", 64'(obs_frame), 64'h400000000095);
    chk("cmd0_oe_bits", 64'(obs_cnt), 64'd48);
    chk("cmd0_latency", 64'(be_cnt), 64'd49);

    send(6'd8, 32'h000001AA, 1'b0); wait_done("cmd8");
    chk("cmd8_frame", 64'(obs_frame), 64'h48000001AA87);

    be_mode = 2;
    send(6'd55, 32'h0, 1'b0); wait_done("cmd55");
    chk("cmd55_frame", 64'(obs_frame), 64'h770000000065);

    be_mode = 0; be_period = 3;
    send(6'd8, 32'h000001AA, 1'b0);
    wait_bits(10);
    send(6'd55, 32'hDEADBEEF, 1'b0);
    wait_done("busy_ignore");
    chk("busy_ignore_frame", 64'(obs_frame), 64'h48000001AA87);

    send(6'd0, 32'h0, 1'b0);
    wait_bits(20);
    @(negedge clk); #2 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_cmd_oe", 64'(cmd_oe), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    #2 reset_n = 1'b1;
    repeat (8) @(negedge clk);
    send(6'd8, 32'h000001AA, 1'b0); wait_done("after_reset");
    chk("after_reset_frame", 64'(obs_frame), 64'h48000001AA87);

    be_mode = 0; be_period = 4;
`ifdef SD_CMD_RESP_EN
    arm(48'h08000001AA13, 5);
    send(6'd8, 32'h000001AA, 1'b1); wait_done("r7");
    chk("r7_index", 64'(resp_index), 64'h08);
    chk("r7_status", 64'(resp_status), 64'h000001AA);
    chk("r7_crc_err", 64'(resp_crc_err), 64'd0);
    chk("r7_timeout", 64'(resp_timeout), 64'd0);

    arm(48'h08000001AA15, 5);
    send(6'd8, 32'h000001AA, 1'b1); wait_done("r7_badcrc");
    chk("r7_badcrc_err", 64'(resp_crc_err), 64'd1);

    arm(48'h08000001AA12, 5);
    send(6'd8, 32'h000001AA, 1'b1); wait_done("r7_endbit");
    chk("r7_endbit_err", 64'(resp_crc_err), 64'd1);

    arm(48'h08000001AA13, 1000);
    send(6'd8, 32'h000001AA, 1'b1); wait_done("timeout");
    chk("timeout_flag", 64'(resp_timeout), 64'd1);
    chk("timeout_status", 64'(resp_status), 64'd0);
    chk("timeout_latency", 64'(be_cnt), 64'd113);
`else
    send(6'd8, 32'h000001AA, 1'b1); wait_done("noresp");
    chk("noresp_latency", 64'(be_cnt), 64'd49);
    chk("noresp_timeout", 64'(resp_timeout), 64'd0);
`endif

    for (int t = 0; t < 25; t++) begin
      be_mode = int'($urandom_range(0, 2));
      be_period = int'($urandom_range(2, 5));
      rexp = RESP_EN && ($urandom_range(0, 2) != 0);
      if (rexp) begin
        ri = 6'($urandom); ra = $urandom;
        rw = mk_resp(ri, ra);
        idle = int'($urandom_range(0, 8));
        case ($urandom_range(0, 4))
          0: rw[$urandom_range(1, 45)] = ~rw[$urandom_range(1, 45)];
          1: rw[0] = 1'b0;
          2: idle = 200;
          default: ;
        endcase
        arm(rw, idle);
      end
      send(6'($urandom), $urandom, rexp);
      wait_done("random");
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: actual=timeout required=finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
